uart_xcvr: RTL and testbench

Self-contained, parametrised UART transceiver that generalises the existing loopback-only UART top. It integrates a programmable baud-tick divider, a TX FIFO and serialiser, an oversampling RX deserialiser and an RX FIFO. It adds external `tx`/`rx` pins, a runtime loopback mode, configurable stop length, sticky frame/parity/overrun error flags and optional parity. It sits between a register-mapped host (push/pop byte interface) and the board serial pins.

---
 rtl/uart_xcvr_if.sv | 37 +++
 rtl/uart_xcvr.sv | 389 ++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_xcvr_if.sv
`default_nettype none
// ============================================================================
// uart_xcvr_if : host-side control/data bundle for uart_xcvr.  Rev 1.0
// ============================================================================
interface uart_xcvr_if #(
  parameter int DBIT   = 8,
  parameter int DVSR_W = 11
);
  logic [DVSR_W-1:0] dvsr;
  logic              loopback;
  logic              wr_en;
  logic [DBIT-1:0]   wr_data;
  logic              rd_en;
  logic [DBIT-1:0]   rd_data;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;
  logic              tx_busy;
  logic              err_clr;
  logic              frame_err;
  logic              parity_err;
  logic              overrun_err;

  modport master (
    output dvsr, loopback, wr_en, wr_data, rd_en, err_clr,
    input  rd_data, tx_full, tx_empty, rx_full, rx_empty, tx_busy,
           frame_err, parity_err, overrun_err
  );

  modport slave (
    input  dvsr, loopback, wr_en, wr_data, rd_en, err_clr,
    output rd_data, tx_full, tx_empty, rx_full, rx_empty, tx_busy,
           frame_err, parity_err, overrun_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_xcvr.sv
`default_nettype none
// ============================================================================
// uart_xcvr : UART transceiver (baud gen, TX/RX FIFOs, serialiser, RX
//             oversampler); parity optional via UART_PARITY_EN.  Rev 1.0
// ============================================================================
module uart_xcvr_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_wr;
  logic          w_do_rd;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_do_rd = rd_en && !empty;
  // a pop in the same cycle frees the slot, so a write to a full FIFO may proceed
  assign w_do_wr = wr_en && (!full || w_do_rd);
  assign rd_data = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + AW'(1);
      if (w_do_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= wr_data;
  end
endmodule

module uart_xcvr #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int FIFO_AW    = 2,
  parameter int DVSR_W     = 11,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  uart_xcvr_if.slave bus
);
  localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam logic [TW-1:0] C_S7      = TW'(7);
  localparam logic [TW-1:0] C_S15     = TW'(15);
  localparam logic [TW-1:0] C_SB_LAST = TW'(SB_TICK - 1);
  localparam logic [2:0]    C_N_LAST  = 3'(DBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_PARITY_EN
    S_PAR   = 3'd3,
`endif
    S_STOP  = 3'd4
  } state_t;

`ifdef UART_PARITY_EN
  localparam state_t C_AFTER_DATA = S_PAR;
  localparam logic   C_ODD        = (PARITY_ODD != 0);
`else
  localparam state_t C_AFTER_DATA = S_STOP;
`endif

  // ---------------- baud tick ----------------
  logic [DVSR_W-1:0] r_baud_cnt;
  logic [DVSR_W-1:0] r_baud_lim;
  logic              w_tick;

  assign w_tick = (r_baud_cnt == r_baud_lim);

  // the limit is re-latched only at wrap so a divisor change never truncates a period
  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud_cnt <= '0;
      r_baud_lim <= bus.dvsr;
    end else if (w_tick) begin
      r_baud_cnt <= '0;
      r_baud_lim <= bus.dvsr;
    end else begin
      r_baud_cnt <= r_baud_cnt + DVSR_W'(1);
    end
  end

  // ---------------- FIFOs ----------------
  logic            w_tx_pop;
  logic [DBIT-1:0] w_tx_head;
  logic            w_tx_full;
  logic            w_tx_empty;
  logic            w_rx_full;
  logic            w_rx_empty;
  logic            r_rx_push;
  logic [DBIT-1:0] r_rx_byte;

  uart_xcvr_fifo #(.W(DBIT), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (w_tx_pop),
    .rd_data (w_tx_head),
    .full    (w_tx_full),
    .empty   (w_tx_empty)
  );

  uart_xcvr_fifo #(.W(DBIT), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (r_rx_push),
    .wr_data (r_rx_byte),
    .rd_en   (bus.rd_en),
    .rd_data (bus.rd_data),
    .full    (w_rx_full),
    .empty   (w_rx_empty)
  );

  assign bus.tx_full  = w_tx_full;
  assign bus.tx_empty = w_tx_empty;
  assign bus.rx_full  = w_rx_full;
  assign bus.rx_empty = w_rx_empty;

  // ---------------- TX FSM ----------------
  state_t          r_tx_state;
  state_t          w_tx_state_n;
  logic [TW-1:0]   r_tx_s;
  logic [TW-1:0]   w_tx_s_n;
  logic [2:0]      r_tx_n;
  logic [2:0]      w_tx_n_n;
  logic [DBIT-1:0] r_tx_shift;
  logic [DBIT-1:0] w_tx_shift_n;
  logic            r_tx_line;
  logic            w_tx_line_n;
`ifdef UART_PARITY_EN
  logic            r_tx_par;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= S_IDLE;
      r_tx_s     <= '0;
      r_tx_n     <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_s     <= w_tx_s_n;
      r_tx_n     <= w_tx_n_n;
      r_tx_shift <= w_tx_shift_n;
      r_tx_line  <= w_tx_line_n;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)         r_tx_par <= 1'b0;
    else if (w_tx_pop) r_tx_par <= (^w_tx_head) ^ C_ODD;
  end
`endif

  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_s_n     = r_tx_s;
    w_tx_n_n     = r_tx_n;
    w_tx_shift_n = r_tx_shift;
    w_tx_line_n  = 1'b1;
    w_tx_pop     = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_shift_n = w_tx_head;
          w_tx_s_n     = '0;
          w_tx_n_n     = '0;
          w_tx_state_n = S_START;
        end
      end
      S_START: begin
        w_tx_line_n = 1'b0;
        if (w_tick) begin
          if (r_tx_s == C_S15) begin
            w_tx_s_n     = '0;
            w_tx_state_n = S_DATA;
          end else begin
            w_tx_s_n = r_tx_s + TW'(1);
          end
        end
      end
      S_DATA: begin
        w_tx_line_n = r_tx_shift[0];
        if (w_tick) begin
          if (r_tx_s == C_S15) begin
            w_tx_s_n     = '0;
            w_tx_shift_n = r_tx_shift >> 1;
            if (r_tx_n == C_N_LAST) w_tx_state_n = C_AFTER_DATA;
            else                    w_tx_n_n     = r_tx_n + 3'd1;
          end else begin
            w_tx_s_n = r_tx_s + TW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        w_tx_line_n = r_tx_par;
        if (w_tick) begin
          if (r_tx_s == C_S15) begin
            w_tx_s_n     = '0;
            w_tx_state_n = S_STOP;
          end else begin
            w_tx_s_n = r_tx_s + TW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          if (r_tx_s == C_SB_LAST) w_tx_state_n = S_IDLE;
          else                     w_tx_s_n     = r_tx_s + TW'(1);
        end
      end
      default: w_tx_state_n = S_IDLE;
    endcase
  end

  assign tx          = r_tx_line | bus.loopback;
  assign bus.tx_busy = (r_tx_state != S_IDLE);

  // ---------------- RX input conditioning ----------------
  logic r_rx_meta;
  logic r_rx_sync;
  logic w_rx_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rx_src = bus.loopback ? r_tx_line : r_rx_sync;

  // ---------------- RX FSM ----------------
  state_t          r_rx_state;
  state_t          w_rx_state_n;
  logic [TW-1:0]   r_rx_s;
  logic [TW-1:0]   w_rx_s_n;
  logic [2:0]      r_rx_n;
  logic [2:0]      w_rx_n_n;
  logic [DBIT-1:0] r_rx_shift;
  logic [DBIT-1:0] w_rx_shift_n;
  logic            w_stop_ok;
  logic            w_stop_bad;
  logic            w_par_bad;
  logic            r_frame_err;
  logic            r_overrun_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state    <= S_IDLE;
      r_rx_s        <= '0;
      r_rx_n        <= '0;
      r_rx_shift    <= '0;
      r_rx_push     <= 1'b0;
      r_rx_byte     <= '0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_rx_state    <= w_rx_state_n;
      r_rx_s        <= w_rx_s_n;
      r_rx_n        <= w_rx_n_n;
      r_rx_shift    <= w_rx_shift_n;
      r_rx_push     <= w_stop_ok;
      if (w_stop_ok) r_rx_byte <= r_rx_shift;
      // set events override a simultaneous clear
      r_frame_err   <= w_stop_bad | (r_frame_err & ~bus.err_clr);
      r_overrun_err <= (r_rx_push & w_rx_full) | (r_overrun_err & ~bus.err_clr);
    end
  end

  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_s_n     = r_rx_s;
    w_rx_n_n     = r_rx_n;
    w_rx_shift_n = r_rx_shift;
    w_stop_ok    = 1'b0;
    w_stop_bad   = 1'b0;
    w_par_bad    = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        if (!w_rx_src) begin
          w_rx_s_n     = '0;
          w_rx_state_n = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_rx_s == C_S7) begin
            w_rx_s_n = '0;
            w_rx_n_n = '0;
            w_rx_state_n = w_rx_src ? S_IDLE : S_DATA;
          end else begin
            w_rx_s_n = r_rx_s + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_rx_s == C_S15) begin
            w_rx_s_n     = '0;
            w_rx_shift_n = {w_rx_src, r_rx_shift[DBIT-1:1]};
            if (r_rx_n == C_N_LAST) w_rx_state_n = C_AFTER_DATA;
            else                    w_rx_n_n     = r_rx_n + 3'd1;
          end else begin
            w_rx_s_n = r_rx_s + TW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        if (w_tick) begin
          if (r_rx_s == C_S15) begin
            w_rx_s_n     = '0;
            w_par_bad    = (w_rx_src != ((^r_rx_shift) ^ C_ODD));
            w_rx_state_n = S_STOP;
          end else begin
            w_rx_s_n = r_rx_s + TW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          if (r_rx_s == C_S15) begin
            w_stop_ok    = w_rx_src;
            w_stop_bad   = !w_rx_src;
            w_rx_state_n = S_IDLE;
          end else begin
            w_rx_s_n = r_rx_s + TW'(1);
          end
        end
      end
      default: w_rx_state_n = S_IDLE;
    endcase
  end

`ifdef UART_PARITY_EN
  logic r_parity_err;
  always_ff @(posedge clk) begin
    if (reset) r_parity_err <= 1'b0;
    else       r_parity_err <= w_par_bad | (r_parity_err & ~bus.err_clr);
  end
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.frame_err   = r_frame_err;
  assign bus.overrun_err = r_overrun_err;
endmodule
`default_nettype wire

// File: tb/tb_uart_xcvr.sv
`default_nettype none
// ============================================================================
// tb_uart_xcvr : directed + random bench for uart_xcvr with a frame-level
//                serial reference model.  Rev 1.0
// ============================================================================
module tb_uart_xcvr;
  localparam int DBIT       = 8;
  localparam int SB_TICK    = 16;
  localparam int FIFO_AW    = 2;
  localparam int DVSR_W     = 11;
  localparam int PARITY_ODD = 0;
  localparam int DVSR       = 3;
  localparam int BIT        = 16 * (DVSR + 1);
`ifdef UART_PARITY_EN
  localparam bit PAR_EN     = 1'b1;
`else
  localparam bit PAR_EN     = 1'b0;
`endif
  localparam bit ODD        = (PARITY_ODD != 0);
  localparam int FRAME      = (1 + DBIT + (PAR_EN ? 1 : 0)) * BIT + SB_TICK * (DVSR + 1);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  logic tx;

  int vectors     = 0;
  int miscompares = 0;
  logic [DBIT-1:0] exp_q[$];

  uart_xcvr_if #(.DBIT(DBIT), .DVSR_W(DVSR_W)) bus ();

  uart_xcvr #(
    .DBIT       (DBIT),
    .SB_TICK    (SB_TICK),
    .FIFO_AW    (FIFO_AW),
    .DVSR_W     (DVSR_W),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .tx    (tx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted (vectors=%0d)", vectors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [DBIT-1:0] b);
    bus.wr_data = b;
    bus.wr_en   = 1'b1;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic pop_rx();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  // serial frame onto the rx pin; stop_len lets the bench shorten a bad stop bit
  task automatic send_rx(input logic [DBIT-1:0] b, input logic par, input logic stop_val,
                         input int stop_len);
    rx = 1'b0;
    cycles(BIT);
    for (int i = 0; i < DBIT; i++) begin
      rx = b[i];
      cycles(BIT);
    end
    if (PAR_EN) begin
      rx = par;
      cycles(BIT);
    end
    rx = stop_val;
    cycles(stop_len);
    rx = 1'b1;
  endtask

  // decode one frame from the tx pin by sampling mid-bit after the falling edge
  task automatic capture_tx(output logic [DBIT-1:0] b, output logic ok);
    int t;
    t  = 0;
    ok = 1'b1;
    b  = '0;
    while (tx !== 1'b0 && t < 4 * FRAME) begin
      @(negedge clk);
      t++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    cycles(BIT / 2 - 1);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < DBIT; i++) begin
      cycles(BIT);
      b[i] = tx;
    end
    if (PAR_EN) begin
      cycles(BIT);
      if (tx !== ((^b) ^ ODD)) ok = 1'b0;
    end
    cycles(BIT);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  initial begin
    logic [DBIT-1:0] b;
    logic [DBIT-1:0] got;
    logic            ok;
    int              n;
    int              lows;

    bus.dvsr     = DVSR_W'(DVSR);
    bus.loopback = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.rd_en    = 1'b0;
    bus.err_clr  = 1'b0;
    reset        = 1'b1;
    cycles(3);

    check("rst_tx", tx, 1);
    check("rst_tx_busy", bus.tx_busy, 0);
    check("rst_tx_empty", bus.tx_empty, 1);
    check("rst_rx_empty", bus.rx_empty, 1);
    check("rst_tx_full", bus.tx_full, 0);
    check("rst_rx_full", bus.rx_full, 0);
    check("rst_errs", {bus.frame_err, bus.parity_err, bus.overrun_err}, 0);
    check("rst_rd_data", bus.rd_data, 0);
    reset = 1'b0;
    cycles(2);

    // TX start latency and serial framing on the pin
    b = DBIT'($urandom);
    push_tx(b);
    check("lat_tx_empty", bus.tx_empty, 0);
    check("lat_busy0", bus.tx_busy, 0);
    cycles(1);
    check("lat_busy1", bus.tx_busy, 1);
    check("lat_tx_idle", tx, 1);
    cycles(1);
    check("lat_start", tx, 0);
    capture_tx(got, ok);
    check("tx_frame_ok", ok, 1);
    check("tx_data", got, b);

    repeat (3) begin
      b = DBIT'($urandom);
      push_tx(b);
      capture_tx(got, ok);
      check("tx_rand_ok", ok, 1);
      check("tx_rand_data", got, b);
    end
    cycles(2 * BIT);

    // loopback single byte, pin held high
    bus.loopback = 1'b1;
    push_tx(8'hA5);
    lows = 0;
    repeat (FRAME + BIT) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("lb_tx_held", lows, 0);
    check("lb_rx_empty", bus.rx_empty, 0);
    check("lb_rd_data", bus.rd_data, 8'hA5);
    check("lb_errs", {bus.frame_err, bus.parity_err, bus.overrun_err}, 0);
    pop_rx();
    check("lb_popped", bus.rx_empty, 1);

    // random loopback bursts against the byte queue
    repeat (3) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        b = DBIT'($urandom);
        exp_q.push_back(b);
        push_tx(b);
      end
      cycles(n * (FRAME + 4) + BIT);
      while (exp_q.size() > 0) begin
        check("burst_nonempty", bus.rx_empty, 0);
        check("burst_data", bus.rd_data, exp_q.pop_front());
        pop_rx();
      end
      check("burst_drained", bus.rx_empty, 1);
    end

    // overrun: five frames into a four-deep RX FIFO, never read
    for (int k = 1; k <= 5; k++) push_tx(DBIT'(k));
    cycles(4 * FRAME + FRAME / 2 - 5);
    check("ovr_full4", bus.rx_full, 1);
    check("ovr_not_yet", bus.overrun_err, 0);
    cycles(FRAME / 2 + BIT);
    check("ovr_set", bus.overrun_err, 1);
    for (int k = 1; k <= 4; k++) begin
      check("ovr_rd", bus.rd_data, k);
      pop_rx();
    end
    check("ovr_empty", bus.rx_empty, 1);
    pulse_clr();
    check("ovr_clr", bus.overrun_err, 0);

    // frame error: stop bit low, released before a fresh start can be confirmed
    bus.loopback = 1'b0;
    cycles(BIT);
    b = 8'h3C;
    send_rx(b, (^b) ^ ODD, 1'b0, (3 * BIT) / 4);
    cycles(2 * BIT);
    check("ferr_set", bus.frame_err, 1);
    check("ferr_no_push", bus.rx_empty, 1);
    pulse_clr();
    check("ferr_clr", bus.frame_err, 0);

    // start glitch shorter than half a bit
    rx = 1'b0;
    cycles(4 * (DVSR + 1));
    rx = 1'b1;
    cycles(2 * BIT);
    check("glitch_no_push", bus.rx_empty, 1);
    check("glitch_errs", {bus.frame_err, bus.parity_err, bus.overrun_err}, 0);

    // random external frames
    repeat (3) begin
      b = DBIT'($urandom);
      send_rx(b, (^b) ^ ODD, 1'b1, BIT);
      cycles(8);
      check("ext_nonempty", bus.rx_empty, 0);
      check("ext_data", bus.rd_data, b);
      check("ext_ferr", bus.frame_err, 0);
      pop_rx();
    end

`ifdef UART_PARITY_EN
    b = 8'h03;
    send_rx(b, ~((^b) ^ ODD), 1'b1, BIT);
    cycles(8);
    check("par_err", bus.parity_err, 1);
    check("par_data", bus.rd_data, 8'h03);
    pop_rx();
    pulse_clr();
    check("par_clr", bus.parity_err, 0);
`endif

    // reset in the third data bit of a TX frame, with RX data and an error pending
    b = DBIT'($urandom);
    send_rx(b, (^b) ^ ODD, 1'b1, BIT);
    send_rx(8'h3C, (^8'h3C) ^ ODD, 1'b0, (3 * BIT) / 4);
    cycles(2 * BIT);
    check("pre_rx_data", bus.rx_empty, 0);
    check("pre_ferr", bus.frame_err, 1);
    push_tx(DBIT'($urandom));
    push_tx(DBIT'($urandom));
    lows = 0;
    while (tx !== 1'b0 && lows < FRAME) begin
      @(negedge clk);
      lows++;
    end
    check("pre_start_seen", tx, 0);
    cycles(3 * BIT + BIT / 2);
    check("pre_busy", bus.tx_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", bus.tx_busy, 0);
    check("mid_rst_tx_empty", bus.tx_empty, 1);
    check("mid_rst_rx_empty", bus.rx_empty, 1);
    check("mid_rst_errs", {bus.frame_err, bus.parity_err, bus.overrun_err}, 0);
    reset = 1'b0;
    cycles(2);

    // post-reset loopback sanity
    bus.loopback = 1'b1;
    b = DBIT'($urandom);
    push_tx(b);
    cycles(FRAME + BIT);
    check("post_rst_nonempty", bus.rx_empty, 0);
    check("post_rst_data", bus.rd_data, b);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
